// File: rtl/mig7_tester.sv
// Write-then-readback tester for the MIG7 user interface: writes a deterministic pattern over an
// address window, reads it back, counts mismatching words and flags read-data timeouts.
module mig7_tester #(
  parameter int unsigned           ADDR_WIDTH = 28,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter int unsigned           ADDR_STEP  = 8,
  parameter int unsigned           WORDS      = 1024,
  parameter int unsigned           TIMEOUT    = 4096,
  parameter int unsigned           ERR_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    loop_i,
  input  logic                    invert_i,
  input  logic                    init_calib_complete_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic [ERR_WIDTH-1:0]    err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   app_addr_o,
  output logic [2:0]              app_cmd_o,
  output logic                    app_en_o,
  input  logic                    app_rdy_i,
  output logic [DATA_WIDTH-1:0]   app_wdf_data_o,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask_o,
  output logic                    app_wdf_wren_o,
  output logic                    app_wdf_end_o,
  input  logic                    app_wdf_rdy_i,
  input  logic [DATA_WIDTH-1:0]   app_rd_data_i,
  input  logic                    app_rd_data_valid_i,
  input  logic                    app_rd_data_end_i,
  output logic                    app_sr_req_o,
  output logic                    app_ref_req_o,
  output logic                    app_zq_req_o,
  input  logic                    app_sr_active_i,
  input  logic                    app_ref_ack_i,
  input  logic                    app_zq_ack_i
);

  localparam int unsigned CntW  = $clog2(WORDS + 1);
  localparam int unsigned TmrW  = $clog2(TIMEOUT + 1);
  localparam int unsigned Lanes = DATA_WIDTH / 32;
  localparam logic [CntW-1:0] Words = CntW'(WORDS);
  localparam logic [CntW:0]   Lead  = (CntW + 1)'(2);

  typedef enum logic [2:0] {StIdle, StWaitCal, StWrite, StRead, StDrain, StFinish} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     wc_q, wc_d, wd_q, wd_d, rc_q, rc_d, rx_q, rx_d;
  logic [TmrW-1:0]     wdog_q, wdog_d;
  logic                inv_q, inv_d, err_q, err_d, timeout_q, timeout_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                new_pass, cmd_en, cmd_rd, wr_en, done;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [CntW-1:0] idx, input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < Lanes; k++) p[32*k +: 32] = (32'(idx) + 32'(k)) ^ {32{inv}};
    return p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CntW-1:0] idx);
    return ADDR_BASE + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STEP);
  endfunction

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    wd_d      = wd_q;
    rc_d      = rc_q;
    rx_d      = rx_q;
    wdog_d    = wdog_q;
    inv_d     = inv_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    err_cnt_d = err_cnt_q;
    new_pass  = 1'b0;
    cmd_en    = 1'b0;
    cmd_rd    = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          new_pass  = 1'b1;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          err_cnt_d = '0;
          state_d   = StWaitCal;
        end
      end
      StWaitCal: begin
        if (init_calib_complete_i) state_d = StWrite;
      end
      StWrite: begin
        // Command may run at most two words ahead of the data path.
        cmd_en = (wc_q != Words) && ({1'b0, wc_q} < {1'b0, wd_q} + Lead);
        wr_en  = (wd_q != Words);
        if (cmd_en && app_rdy_i)    wc_d = wc_q + CntW'(1);
        if (wr_en && app_wdf_rdy_i) wd_d = wd_q + CntW'(1);
        if (wc_q == Words && wd_q == Words) state_d = StRead;
      end
      StRead: begin
        cmd_en = (rc_q != Words);
        cmd_rd = 1'b1;
        if (cmd_en && app_rdy_i) rc_d = rc_q + CntW'(1);
        if (rc_q == Words) state_d = StDrain;
      end
      StDrain: begin
        if (rx_q == Words) state_d = StFinish;
      end
      StFinish: begin
        done = 1'b1;
        if (loop_i) begin
          new_pass = 1'b1;
          state_d  = StWaitCal;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StRead || state_q == StDrain) begin
      if (app_rd_data_valid_i && rx_q != Words) begin
        rx_d = rx_q + CntW'(1);
        if (app_rd_data_i != pattern(rx_q, inv_q)) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
        end
      end
      // Watchdog only runs while reads are outstanding.
      if (app_rd_data_valid_i || rx_q >= rc_q) begin
        wdog_d = '0;
      end else begin
        wdog_d = wdog_q + TmrW'(1);
        if (wdog_d == TmrW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          err_d     = 1'b1;
          state_d   = StFinish;
        end
      end
    end

    if (new_pass) begin
      wc_d   = '0;
      wd_d   = '0;
      rc_d   = '0;
      rx_d   = '0;
      wdog_d = '0;
      inv_d  = invert_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wc_q      <= '0;
      wd_q      <= '0;
      rc_q      <= '0;
      rx_q      <= '0;
      wdog_q    <= '0;
      inv_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      wd_q      <= wd_d;
      rc_q      <= rc_d;
      rx_q      <= rx_d;
      wdog_q    <= wdog_d;
      inv_q     <= inv_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = done;
  assign err_o          = err_q;
  assign timeout_o      = timeout_q;
  assign err_cnt_o      = err_cnt_q;
  assign app_en_o       = cmd_en;
  assign app_cmd_o      = {2'b00, cmd_rd & cmd_en};
  assign app_addr_o     = cmd_en ? word_addr(cmd_rd ? rc_q : wc_q) : '0;
  assign app_wdf_wren_o = wr_en;
  assign app_wdf_end_o  = wr_en;
  assign app_wdf_data_o = wr_en ? pattern(wd_q, inv_q) : '0;
  assign app_wdf_mask_o = '0;
  assign app_sr_req_o   = 1'b0;
  assign app_ref_req_o  = 1'b0;
  assign app_zq_req_o   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{app_rd_data_end_i, app_sr_active_i, app_ref_ack_i, app_zq_ack_i};

endmodule

// File: tb/tb_mig7_tester.sv
// Bench for mig7_tester: a MIG user-interface model with memory, stalls, corruption and dropped
// beats, checked against reference address/pattern arithmetic.
module tb_mig7_tester;

  localparam int unsigned AW    = 28;
  localparam int unsigned DW    = 128;
  localparam int unsigned EW    = 16;
  localparam int unsigned WORDS = 16;
  localparam int unsigned TMO   = 64;
  localparam int unsigned STEP  = 8;
  localparam int          LAT   = 20;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_ni, start_i, loop_i, invert_i, cal_i;
  logic           busy_o, done_o, err_o, timeout_o;
  logic [EW-1:0]  err_cnt_o;
  logic [AW-1:0]  app_addr_o;
  logic [2:0]     app_cmd_o;
  logic           app_en_o, app_rdy_i;
  logic [DW-1:0]  app_wdf_data_o;
  logic [DW/8-1:0] app_wdf_mask_o;
  logic           app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic [DW-1:0]  app_rd_data_i;
  logic           app_rd_data_valid_i;
  logic           app_sr_req_o, app_ref_req_o, app_zq_req_o;

  mig7_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_BASE('0), .ADDR_STEP(STEP), .WORDS(WORDS),
    .TIMEOUT(TMO), .ERR_WIDTH(EW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_i(loop_i), .invert_i(invert_i),
    .init_calib_complete_i(cal_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .app_addr_o(app_addr_o),
    .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
    .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_rdy_i(app_wdf_rdy_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_end_i(app_rd_data_valid_i),
    .app_sr_req_o(app_sr_req_o), .app_ref_req_o(app_ref_req_o), .app_zq_req_o(app_zq_req_o),
    .app_sr_active_i(1'b0), .app_ref_ack_i(1'b0), .app_zq_ack_i(1'b0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] ref_addr(input int i);
    return AW'(i * STEP);
  endfunction

  function automatic logic [DW-1:0] ref_word(input int i, input bit inv);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = inv ? ~32'(i + k) : 32'(i + k);
    return w;
  endfunction

  // MIG model state
  bit             stall = 0;
  bit             inv_ref = 0;
  logic [WORDS-1:0] corrupt_mask = '0;
  int             drop_idx = -1;
  int             cyc = 0;
  int             wc_ref, wd_ref, rc_ref, done_cnt, en_cnt, last_beat, last_done;
  logic [AW-1:0]  wcmd_q[$];
  logic [DW-1:0]  wdat_q[$];
  int             rd_due[$], rd_idx[$];
  logic [AW-1:0]  rd_addr[$];
  logic [DW-1:0]  mem[logic [AW-1:0]];
  logic [AW-1:0]  waddr_seen[WORDS];
  logic [DW-1:0]  wdata_seen[WORDS];
  bit             pend_cmd, pend_dat;
  logic [AW-1:0]  pend_addr, m_addr;
  logic [DW-1:0]  pend_data;
  int             m_idx;

  task automatic model_clear();
    wc_ref = 0; wd_ref = 0; rc_ref = 0; en_cnt = 0;
    wcmd_q.delete(); wdat_q.delete(); rd_due.delete(); rd_idx.delete(); rd_addr.delete();
    pend_cmd = 0; pend_dat = 0;
  endtask

  always @(negedge clk_i) begin
    app_rdy_i           = stall ? 1'($urandom_range(1)) : 1'b1;
    app_wdf_rdy_i       = stall ? 1'($urandom_range(1)) : 1'b1;
    app_rd_data_valid_i = 1'b0;
    app_rd_data_i       = {$urandom, $urandom, $urandom, $urandom};
    if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
      void'(rd_due.pop_front());
      m_idx  = rd_idx.pop_front();
      m_addr = rd_addr.pop_front();
      if (m_idx != drop_idx) begin
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i = mem.exists(m_addr) ? mem[m_addr] : '0;
        if (m_idx < WORDS && corrupt_mask[m_idx]) app_rd_data_i[0] = ~app_rd_data_i[0];
        last_beat = cyc;
      end
    end
    #1;
    if (pend_cmd) begin
      check("cmd_hold_en", app_en_o, 1);
      check("cmd_hold_addr", app_addr_o, pend_addr);
    end
    pend_cmd  = app_en_o && !app_rdy_i;
    pend_addr = app_addr_o;
    if (pend_dat) begin
      check("wdat_hold_wren", app_wdf_wren_o, 1);
      check("wdat_hold_data", app_wdf_data_o, pend_data);
    end
    pend_dat  = app_wdf_wren_o && !app_wdf_rdy_i;
    pend_data = app_wdf_data_o;
    if (app_en_o) en_cnt++;
    if (app_en_o && app_rdy_i) begin
      if (app_cmd_o == 3'b000) begin
        check("wr_addr", app_addr_o, ref_addr(wc_ref));
        check("cmd_lead", (wc_ref + 1 <= wd_ref + 2), 1);
        if (wc_ref < WORDS) waddr_seen[wc_ref] = app_addr_o;
        wcmd_q.push_back(app_addr_o);
        wc_ref++;
      end else begin
        check("rd_cmd", app_cmd_o, 3'b001);
        check("rd_addr", app_addr_o, ref_addr(rc_ref));
        rd_due.push_back(cyc + LAT);
        rd_idx.push_back(rc_ref);
        rd_addr.push_back(app_addr_o);
        rc_ref++;
      end
    end
    if (app_wdf_wren_o && app_wdf_rdy_i) begin
      check("wr_data", app_wdf_data_o, ref_word(wd_ref, inv_ref));
      check("wdf_end", app_wdf_end_o, 1);
      if (wd_ref < WORDS) wdata_seen[wd_ref] = app_wdf_data_o;
      wdat_q.push_back(app_wdf_data_o);
      wd_ref++;
    end
    while (wcmd_q.size() > 0 && wdat_q.size() > 0) mem[wcmd_q.pop_front()] = wdat_q.pop_front();
    if (done_o) begin
      done_cnt++;
      last_done = cyc;
      model_clear();
    end
    cyc++;
  end

  task automatic pulse_start();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk_i);
    #2;
    check("done_cnt", done_cnt, target);
  endtask

  task automatic run_pass(input bit inv, input int budget);
    model_clear();
    done_cnt = 0;
    invert_i = inv;
    inv_ref  = inv;
    pulse_start();
    wait_done(1, budget);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; loop_i = 1'b0; invert_i = 1'b0; cal_i = 1'b1;
    model_clear();
    done_cnt = 0;
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_app_en", app_en_o, 0);
    check("rst_wren", app_wdf_wren_o, 0);
    check("rst_addr", app_addr_o, 0);
    check("req_consts", {app_sr_req_o, app_ref_req_o, app_zq_req_o, |app_wdf_mask_o}, 0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Ideal memory, plain pattern
    run_pass(0, 500);
    check("t1_err", err_o, 0);
    check("t1_err_cnt", err_cnt_o, 0);
    check("t1_timeout", timeout_o, 0);
    check("t1_w5_lane0", wdata_seen[5][31:0], 32'h5);
    check("t1_w5_addr", waddr_seen[5], 40);
    check("t1_done_after_reads", last_done > last_beat, 1);
    @(negedge clk_i);
    #2;
    check("t1_idle", busy_o, 0);

    // Two corrupted readback words
    corrupt_mask = '0;
    corrupt_mask[3] = 1'b1;
    corrupt_mask[9] = 1'b1;
    run_pass(0, 500);
    check("t2_err_cnt", err_cnt_o, 2);
    check("t2_err", err_o, 1);
    repeat (30) @(negedge clk_i);
    #2;
    check("t2_single_done", done_cnt, 1);
    corrupt_mask = '0;

    // Late calibration
    cal_i = 1'b0;
    model_clear();
    done_cnt = 0;
    pulse_start();
    repeat (100) @(negedge clk_i);
    #2;
    check("t3_no_cmd", en_cnt, 0);
    check("t3_busy", busy_o, 1);
    check("t3_err_cleared", err_o, 0);
    cal_i = 1'b1;
    wait_done(1, 500);
    check("t3_err_cnt", err_cnt_o, 0);

    // Random stalls, inverted pattern
    stall = 1;
    run_pass(1, 3000);
    check("t4_err", err_o, 0);
    check("t4_err_cnt", err_cnt_o, 0);
    check("t4_timeout", timeout_o, 0);
    stall = 0;

    // Dropped final beat
    drop_idx = WORDS - 1;
    run_pass(0, 1000);
    check("t5_timeout", timeout_o, 1);
    check("t5_err", err_o, 1);
    check("t5_err_cnt", err_cnt_o, 0);
    check("t5_gap", (last_done - last_beat >= TMO) && (last_done - last_beat <= TMO + 1), 1);
    drop_idx = -1;

    // Looping passes keep err_cnt, then reset mid-write
    corrupt_mask = '0;
    corrupt_mask[3] = 1'b1;
    loop_i = 1'b1;
    model_clear();
    done_cnt = 0;
    invert_i = 1'b0;
    inv_ref  = 1'b0;
    pulse_start();
    wait_done(3, 1500);
    check("t6_err_cnt_kept", err_cnt_o, 3);
    check("t6_err", err_o, 1);
    for (int i = 0; i < 200 && wc_ref < 4; i++) @(negedge clk_i);
    #2;
    check("t6_mid_write", (wc_ref >= 4) && busy_o, 1);
    @(negedge clk_i) rst_ni = 1'b0;
    #2;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_app_en", app_en_o, 0);
    check("t6_rst_err_cnt", err_cnt_o, 0);
    check("t6_rst_err", err_o, 0);
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    #2;
    check("t6_no_done", done_cnt, 3);
    check("t6_stay_idle", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
